// File: rtl/ifid_pkg.sv
// Shared types for the IF/ID decoupling queue: the stored entry layout and its bubble value.
package ifid_pkg;

  // Field width of the stored entry; the queue's XLEN must not exceed this.
  localparam int unsigned IFID_XLEN = 32;

  typedef struct packed {
    logic [IFID_XLEN-1:0] instruction;
    logic [IFID_XLEN-1:0] pcadd4;
    logic [IFID_XLEN-1:0] restartpc;
    logic                 isbds;
  } ifid_entry_t;

  localparam ifid_entry_t IFID_NOP_ENTRY = '0;

  function automatic ifid_entry_t ifid_make_entry(input logic [IFID_XLEN-1:0] instruction,
                                                  input logic [IFID_XLEN-1:0] pcadd4,
                                                  input logic [IFID_XLEN-1:0] restartpc,
                                                  input logic                 isbds);
    ifid_entry_t e;
    e.instruction = instruction;
    e.pcadd4      = pcadd4;
    e.restartpc   = restartpc;
    e.isbds       = isbds;
    return e;
  endfunction

endpackage

// File: rtl/ifid_queue_mem.sv
// Entry storage for ifid_queue: DEPTH registers, one synchronous write port, one async read port.
module ifid_queue_mem
  import ifid_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [PtrW-1:0]   wr_addr,
  input  ifid_entry_t       wr_data,
  input  logic [PtrW-1:0]   rd_addr,
  output ifid_entry_t       rd_data
);

  ifid_entry_t mem_q [DEPTH];

  // Contents need no reset: occupancy is tracked by the owner, stale slots are never shown.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/ifid_queue.sv
// IF/ID decoupling queue with exception flush and branch-redirect squash that keeps the delay slot.
module ifid_queue
  import ifid_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       if_valid,
  output logic                       if_ready,
  input  logic [XLEN-1:0]            if_instruction,
  input  logic [XLEN-1:0]            if_pcadd4,
  input  logic [XLEN-1:0]            if_restartpc,
  input  logic                       if_isbds,
  input  logic                       id_stall,
  output logic                       id_valid,
  output logic [XLEN-1:0]            id_instruction,
  output logic [XLEN-1:0]            id_pcadd4,
  output logic [XLEN-1:0]            id_restartpc,
  output logic                       id_isbds,
  output logic                       id_isflushed,
  input  logic                       flush,
  input  logic                       redirect,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic        full, empty, push, pop, mem_we;
  ifid_entry_t wr_entry, head;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = if_valid && !full;
  assign pop   = !empty && !id_stall;

  assign wr_entry = ifid_make_entry(IFID_XLEN'(if_instruction), IFID_XLEN'(if_pcadd4),
                                    IFID_XLEN'(if_restartpc), if_isbds);

  ifid_queue_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clock   (clock),
    .wr_en   (mem_we),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_q),
    .rd_data (head)
  );

  // DEPTH is a power of two, so pointer arithmetic wraps naturally modulo DEPTH.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_we   = 1'b0;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (pop && redirect && (count_q >= CntW'(2))) begin
      // Keep only the delay slot behind the taken branch; the incoming push is wrong-path.
      rd_ptr_d = rd_ptr_q + PtrW'(1);
      wr_ptr_d = rd_ptr_q + PtrW'(2);
      count_d  = CntW'(1);
    end else begin
      // With one entry, a redirect is an ordinary pop: the same-cycle push is the delay slot.
      mem_we = push;
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    if_ready       = !full;
    id_valid       = !empty;
    id_isflushed   = empty;
    count          = count_q;
    id_instruction = IFID_NOP_ENTRY.instruction[XLEN-1:0];
    id_pcadd4      = IFID_NOP_ENTRY.pcadd4[XLEN-1:0];
    id_restartpc   = IFID_NOP_ENTRY.restartpc[XLEN-1:0];
    id_isbds       = IFID_NOP_ENTRY.isbds;
    if (!empty) begin
      id_instruction = head.instruction[XLEN-1:0];
      id_pcadd4      = head.pcadd4[XLEN-1:0];
      id_restartpc   = head.restartpc[XLEN-1:0];
      id_isbds       = head.isbds;
    end
  end

  a_count_bound : assert property (@(posedge clock) disable iff (!reset_n)
    count_q <= CntW'(DEPTH));
  a_ptr_gap : assert property (@(posedge clock) disable iff (!reset_n)
    (wr_ptr_q - rd_ptr_q) == PtrW'(count_q));

endmodule

// File: tb/tb_ifid_queue.sv
// Self-checking bench for ifid_queue: queue-based reference model plus directed scenarios.
module tb_ifid_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            if_valid = 1'b0;
  logic            if_ready;
  logic [XLEN-1:0] if_instruction = '0;
  logic [XLEN-1:0] if_pcadd4 = '0;
  logic [XLEN-1:0] if_restartpc = '0;
  logic            if_isbds = 1'b0;
  logic            id_stall = 1'b0;
  logic            id_valid;
  logic [XLEN-1:0] id_instruction;
  logic [XLEN-1:0] id_pcadd4;
  logic [XLEN-1:0] id_restartpc;
  logic            id_isbds;
  logic            id_isflushed;
  logic            flush = 1'b0;
  logic            redirect = 1'b0;
  logic [$clog2(DEPTH+1)-1:0] count;

  always #5 clock = ~clock;

  ifid_queue #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instruction (if_instruction),
    .if_pcadd4      (if_pcadd4),
    .if_restartpc   (if_restartpc),
    .if_isbds       (if_isbds),
    .id_stall       (id_stall),
    .id_valid       (id_valid),
    .id_instruction (id_instruction),
    .id_pcadd4      (id_pcadd4),
    .id_restartpc   (id_restartpc),
    .id_isbds       (id_isbds),
    .id_isflushed   (id_isflushed),
    .flush          (flush),
    .redirect       (redirect),
    .count          (count)
  );

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc4;
    logic [31:0] rpc;
    logic        bds;
  } ent_t;

  ent_t mq[$];
  int   checks = 0;
  int   errors = 0;
  bit   started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain list of entries updated from the rules at each clock edge.
  bit   m_push, m_pop;
  ent_t m_in, m_keep;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
    end else begin
      m_push = if_valid && (mq.size() < DEPTH);
      m_pop  = (mq.size() > 0) && !id_stall;
      m_in   = '{if_instruction, if_pcadd4, if_restartpc, if_isbds};
      if (flush) begin
        mq.delete();
      end else if (m_pop && redirect) begin
        if (mq.size() >= 2) begin
          m_keep = mq[1];
          mq.delete();
          mq.push_back(m_keep);
        end else begin
          mq.delete();
          if (m_push) mq.push_back(m_in);
        end
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_push) mq.push_back(m_in);
      end
    end
  end

  ent_t exp_h;
  always @(negedge clock) begin
    if (started) begin
      exp_h = (mq.size() > 0) ? mq[0] : '{32'h0, 32'h0, 32'h0, 1'b0};
      chk("count", 32'(count), 32'(mq.size()));
      chk("if_ready", 32'(if_ready), 32'(mq.size() < DEPTH));
      chk("id_valid", 32'(id_valid), 32'(mq.size() > 0));
      chk("id_isflushed", 32'(id_isflushed), 32'(mq.size() == 0));
      chk("id_instruction", id_instruction, exp_h.ins);
      chk("id_pcadd4", id_pcadd4, exp_h.pc4);
      chk("id_restartpc", id_restartpc, exp_h.rpc);
      chk("id_isbds", 32'(id_isbds), 32'(exp_h.bds));
    end
  end

  task automatic step(input bit v, input logic [31:0] ins, input bit bds, input bit stall,
                      input bit fl = 1'b0, input bit rd = 1'b0);
    if_valid       = v;
    if_instruction = ins;
    if_pcadd4      = ins + 32'd4;
    if_restartpc   = ins ^ 32'hFFFF_0000;
    if_isbds       = bds;
    id_stall       = stall;
    flush          = fl;
    redirect       = rd;
    @(posedge clock);
    #1;
  endtask

  initial begin
    started = 1;
    @(posedge clock);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_if_ready", 32'(if_ready), 32'd1);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_isflushed", 32'(id_isflushed), 32'd1);
    chk("rst_instr", id_instruction, 32'h0);
    reset_n = 1'b1;

    // First push after reset is visible the next cycle.
    step(1, 32'h2402_0001, 0, 1);
    chk("first_valid", 32'(id_valid), 32'd1);
    chk("first_instr", id_instruction, 32'h2402_0001);
    chk("first_count", 32'(count), 32'd1);
    step(0, 32'h0, 0, 0);

    // Fill past capacity while stalled; fifth push refused, full pop does not admit a push.
    for (int i = 0; i < 5; i++) step(1, 32'hA000_0000 + i, 0, 1);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(if_ready), 32'd0);
    chk("full_head", id_instruction, 32'hA000_0000);
    step(1, 32'hA000_00FF, 0, 0);
    chk("fullpop_count", 32'(count), 32'd3);
    for (int i = 1; i < 4; i++) begin
      chk("drain_order", id_instruction, 32'hA000_0000 + i);
      step(0, 32'h0, 0, 0);
    end
    chk("drained_count", 32'(count), 32'd0);

    // Flush with a same-cycle push.
    step(1, 32'hAAAA_0001, 0, 1);
    step(1, 32'hBBBB_0002, 0, 1);
    step(1, 32'hCCCC_0003, 0, 1);
    step(1, 32'hDDDD_0004, 0, 1, 1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_isflushed", 32'(id_isflushed), 32'd1);
    chk("flush_instr", id_instruction, 32'h0);

    // Redirect from a full queue keeps only the delay slot.
    step(1, 32'h1022_0003, 0, 1);
    step(1, 32'h2403_0005, 1, 1);
    step(1, 32'h0000_0A0A, 0, 1);
    step(1, 32'h0000_0B0B, 0, 1);
    step(0, 32'h0, 0, 1, 0, 1);
    chk("nopop_redirect_count", 32'(count), 32'd4);
    step(0, 32'h0, 0, 0, 0, 1);
    chk("redir_count", 32'(count), 32'd1);
    chk("redir_head", id_instruction, 32'h2403_0005);
    chk("redir_isbds", 32'(id_isbds), 32'd1);
    step(0, 32'h0, 0, 0);

    // Redirect with three entries drops the same-cycle push.
    step(1, 32'h1022_0013, 0, 1);
    step(1, 32'h2403_0015, 1, 1);
    step(1, 32'h0000_0C0C, 0, 1);
    step(1, 32'h0000_0D0D, 0, 0, 0, 1);
    chk("redir3_count", 32'(count), 32'd1);
    chk("redir3_head", id_instruction, 32'h2403_0015);
    step(0, 32'h0, 0, 0);

    // Single entry: the same-cycle push is the delay slot.
    step(1, 32'h0800_0040, 0, 1);
    step(1, 32'h2404_0007, 1, 0, 0, 1);
    chk("redir1_count", 32'(count), 32'd1);
    chk("redir1_head", id_instruction, 32'h2404_0007);
    chk("redir1_isbds", 32'(id_isbds), 32'd1);
    step(0, 32'h0, 0, 0, 0, 1);
    chk("redir1_empty", 32'(count), 32'd0);

    // Streaming across several pointer wraps, with occasional stalls.
    for (int i = 0; i < 3 * DEPTH + 4; i++) begin
      step(1, 32'h5000_0000 + i, i[0], (i < 2) || (i % 5 == 3));
    end

    // Asynchronous reset mid-stream.
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_valid", 32'(id_valid), 32'd0);
    chk("async_rst_ready", 32'(if_ready), 32'd1);
    step(1, 32'h6000_0000, 0, 1);
    chk("in_rst_count", 32'(count), 32'd0);
    reset_n = 1'b1;
    step(1, 32'h6000_0001, 0, 1);
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_head", id_instruction, 32'h6000_0001);
    step(0, 32'h0, 0, 0);
    step(0, 32'h0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
